// File: rtl/eth_mii_gmii_tx.sv
// Ethernet TX framer for MII/GMII PHYs.
// Adds preamble/SFD, zero padding, CRC-32 FCS and inter-frame gap.
module eth_mii_gmii_tx #(
   parameter int DATA_WIDTH       = 4,
   parameter int ENABLE_PADDING   = 1,
   parameter int MIN_FRAME_LENGTH = 64,
   parameter int IFG_BYTES        = 12
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [7:0]            s_axis_tdata,
   input  logic                  s_axis_tvalid,
   output logic                  s_axis_tready,
   input  logic                  s_axis_tlast,
   input  logic                  s_axis_tuser,
   output logic [DATA_WIDTH-1:0] phy_txd,
   output logic                  phy_tx_en,
   output logic                  phy_tx_er,
   output logic                  busy,
   output logic                  start_packet,
   output logic                  error_underflow
);

   localparam logic [15:0] L_MIN_DATA = 16'(MIN_FRAME_LENGTH - 4);
   localparam logic [15:0] L_IFG_LAST = 16'(IFG_BYTES - 1);

   typedef enum logic [2:0] {
      S_IDLE, S_PRE, S_PAY, S_PAD, S_FCS, S_ERR, S_IFG
   } state_t;

   state_t                r_state;
   state_t                w_nxt;
   logic                  r_phase;
   logic                  w_last;
   logic [15:0]           r_idx;
   logic [15:0]           r_len;
   logic [15:0]           w_len_inc;
   logic [31:0]           r_crc;
   logic [31:0]           w_fcs;
   logic [7:0]            r_data;
   logic                  r_last;
   logic                  r_bad;
   logic [7:0]            w_byte;
   logic                  w_en;
   logic                  w_er;
   logic                  w_uf;
   logic                  w_start;
   logic                  w_tready;
   logic [DATA_WIDTH-1:0] w_sym;
   logic [DATA_WIDTH-1:0] r_txd;
   logic                  r_en;
   logic                  r_er;
   logic                  r_start;
   logic                  r_uf;

   function automatic logic [31:0] f_crc_byte(
      input logic [31:0] i_crc,
      input logic [7:0]  i_byte
   );
      logic [31:0] v_c;
      v_c = i_crc ^ {24'h0, i_byte};
      for (int k = 0; k < 8; k++) begin
         v_c = v_c[0] ? ((v_c >> 1) ^ 32'hEDB88320) : (v_c >> 1);
      end
      return v_c;
   endfunction

   // MII spends two cycles per byte; GMII finishes every byte in one.
   assign w_last    = (DATA_WIDTH == 8) ? 1'b1 : r_phase;
   assign w_len_inc = (r_len == 16'hFFFF) ? r_len : r_len + 16'd1;
   assign w_fcs     = ~r_crc;

   generate
      if (DATA_WIDTH == 8) begin : g_gmii
         assign w_sym = w_byte;
      end else begin : g_mii
         assign w_sym = r_phase ? w_byte[7:4] : w_byte[3:0];
      end
   endgenerate

   always_comb begin
      w_nxt    = r_state;
      w_tready = 1'b0;
      w_byte   = 8'h00;
      w_en     = 1'b0;
      w_er     = 1'b0;
      w_uf     = 1'b0;
      w_start  = 1'b0;
      unique case (r_state)
         S_IDLE: begin
            if (s_axis_tvalid) begin
               w_nxt   = S_PRE;
               w_start = 1'b1;
            end
         end
         S_PRE: begin
            w_en   = 1'b1;
            w_byte = (r_idx == 16'd7) ? 8'hD5 : 8'h55;
            if (w_last && r_idx == 16'd7) begin
               w_tready = 1'b1;
               w_uf     = ~s_axis_tvalid;
               w_nxt    = s_axis_tvalid ? S_PAY : S_ERR;
            end
         end
         S_PAY: begin
            w_en   = 1'b1;
            w_byte = r_data;
            if (w_last) begin
               if (r_last) begin
                  w_nxt = ((ENABLE_PADDING != 0) && (w_len_inc < L_MIN_DATA))
                          ? S_PAD : S_FCS;
               end else begin
                  w_tready = 1'b1;
                  if (!s_axis_tvalid) begin
                     w_nxt = S_ERR;
                     w_uf  = 1'b1;
                  end
               end
            end
         end
         S_PAD: begin
            w_en = 1'b1;
            if (w_last && w_len_inc >= L_MIN_DATA) w_nxt = S_FCS;
         end
         S_FCS: begin
            w_en = 1'b1;
            w_er = r_bad;
            unique case (r_idx[1:0])
               2'd0: w_byte = w_fcs[7:0];
               2'd1: w_byte = w_fcs[15:8];
               2'd2: w_byte = w_fcs[23:16];
               2'd3: w_byte = w_fcs[31:24];
            endcase
            if (w_last && r_idx == 16'd3) w_nxt = S_IFG;
         end
         S_ERR: begin
            w_en = 1'b1;
            w_er = 1'b1;
            if (w_last) w_nxt = S_IFG;
         end
         S_IFG: begin
            // A waiting source restarts straight from the gap, no idle cycle.
            if (w_last && r_idx == L_IFG_LAST) begin
               w_nxt   = s_axis_tvalid ? S_PRE : S_IDLE;
               w_start = s_axis_tvalid;
            end
         end
         default: w_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_phase <= 1'b0;
         r_idx   <= 16'd0;
         r_len   <= 16'd0;
         r_crc   <= 32'hFFFFFFFF;
         r_data  <= 8'h00;
         r_last  <= 1'b0;
         r_bad   <= 1'b0;
         r_txd   <= '0;
         r_en    <= 1'b0;
         r_er    <= 1'b0;
         r_start <= 1'b0;
         r_uf    <= 1'b0;
      end else begin
         r_state <= w_nxt;
         r_phase <= (r_state == S_IDLE) ? 1'b0 : ~r_phase;
         if (w_nxt != r_state) r_idx <= 16'd0;
         else if (w_last)      r_idx <= r_idx + 16'd1;
         r_txd   <= w_sym;
         r_en    <= w_en;
         r_er    <= w_er;
         r_start <= w_start;
         r_uf    <= w_uf;
         if (w_start) begin
            r_crc <= 32'hFFFFFFFF;
            r_len <= 16'd0;
         end else if (w_last && (r_state == S_PAY || r_state == S_PAD)) begin
            r_crc <= f_crc_byte(r_crc, w_byte);
            r_len <= w_len_inc;
         end
         if (w_tready && s_axis_tvalid) begin
            r_data <= s_axis_tdata;
            r_last <= s_axis_tlast;
            r_bad  <= s_axis_tlast & s_axis_tuser;
         end
      end
   end

   assign s_axis_tready   = w_tready;
   assign phy_txd         = r_txd;
   assign phy_tx_en       = r_en;
   assign phy_tx_er       = r_er;
   assign busy            = (r_state != S_IDLE);
   assign start_packet    = r_start;
   assign error_underflow = r_uf;

endmodule
